gray_ptr_sync: RTL and testbench
================================

// Module: gray_ptr_sync
// PURPOSE
//  One side (write or read) of an async-FIFO pointer pair, running in a single clock domain.
//  - Keeps a local binary pointer and a registered Gray pointer that is glitch-free for clock-domain crossing (CDC).
//  - Synchronises the other domain's Gray pointer and decodes it to binary.
//  - Produces a registered full (write mode) or empty (read mode) flag and an occupancy level.
//  - Two instances, one per clock domain, form the FIFO pointer logic around a dual-port RAM.
// PARAMETERS
//  ADDR_WIDTH   4  RAM address bits; pointers are PW = ADDR_WIDTH+1 bits (extra wrap bit)
//  SYNC_STAGES  2  flops in remote-pointer synchroniser; legal 2..4, else $error at elaboration
//  IS_WRITE     1  1: write side (blocked_o = full); 0: read side (blocked_o = empty)
// PORTS
//  clk            in   1           this domain's clock
//  rst            in   1           synchronous, active-high reset
//  inc_i          in   1           request to advance local pointer (push or pop)
//  ptr_bin_o      out  PW          local binary pointer (registered)
//  ptr_gray_o     out  PW          local Gray pointer (registered); the only signal sent to the other domain
//  addr_o         out  ADDR_WIDTH  ptr_bin_o[ADDR_WIDTH-1:0]; RAM address
//  remote_gray_i  in   PW          other domain's ptr_gray_o (asynchronous)
//  remote_bin_o   out  PW          synchronised, decoded remote pointer
//  blocked_o      out  1           full (IS_WRITE=1) / empty (IS_WRITE=0), registered
//  level_o        out  PW          entries in FIFO as seen from this side, 0..2^ADDR_WIDTH
// BEHAVIOUR
//  - Reset (rst=1 at posedge), values at the next edge:
//    ptr_bin_o=0, ptr_gray_o=0, all sync flops=0, remote_bin_o=0, level_o=0.
//    blocked_o=0 when IS_WRITE=1, 1 when IS_WRITE=0.
//    Mid-operation reset clears everything in that one edge; in-flight increments are lost.
//  - Advance: adv = inc_i & ~blocked_o. inc_i while blocked is ignored, with no state change.
//  - Next pointers: bin_nxt = ptr_bin_o + adv (mod 2^PW); gray_nxt = bin_nxt ^ (bin_nxt>>1).
//    Both are registered on the same edge. ptr_gray_o is driven only from a flop, never from logic.
//  - Wrap: ptr_bin 2^PW-1 -> 0; Gray 10..0 -> 0. Exactly one Gray bit changes per advance, including on wrap.
//  - Synchroniser: remote_gray_i passes through SYNC_STAGES flops; sync_q is the last stage.
//    remote_bin_o = gray2bin(sync_q), combinational: bin[PW-1]=g[PW-1]; bin[i]=g[i]^bin[i+1].
//    Latency: a stable remote_gray_i change appears on remote_bin_o after SYNC_STAGES edges.
//  - Flags are registered from next-state values, so the flag is valid in the same cycle as the new pointer:
//    write: blocked_nxt = (gray_nxt == {~sync_q[PW-1:PW-2], sync_q[PW-3:0]})
//    read:  blocked_nxt = (gray_nxt == sync_q)
//    ADDR_WIDTH=1 (PW=2): the write compare is ~sync_q alone.
//  - level_o (combinational, modulo 2^PW): write = ptr_bin_o - remote_bin_o; read = remote_bin_o - ptr_bin_o.
//  - Simultaneous advance and remote change: the flag uses the new local pointer and the current sync_q.
//    It is pessimistic: full or empty may persist up to SYNC_STAGES+1 cycles after the remote side frees
//    or fills space. It never under-reports.
//  - No overflow or underflow is possible through this block; blocked gating is the only protection.
// STRUCTURE
//  - gray_pkg: ptr_t typedef helper; functions bin2gray(), gray2bin() parametrised by width;
//    localparam PW derivation macro.
//  - Sub-module gray_sync_chain #(WIDTH, STAGES): reset-to-0 flop chain with a synthesis
//    async_reg attribute; used for remote_gray_i.
//  - Top: pointer regs, flag reg, level subtract.
// TESTING
//  1. Reset: hold rst 3 cycles with inc_i=1 -> all pointers 0; blocked_o=0 (write) / 1 (read); level_o=0.
//  2. Write, AW=4, remote held 0: 16 inc pulses -> ptr_bin=16, ptr_gray=5'b11000, blocked_o=1 on the
//     same edge; 17th inc ignored, ptr unchanged.
//  3. Read, AW=4: remote_gray_i set to bin2gray(5) -> remote_bin_o=5 after 2 edges, empty_o falls,
//     level_o=5; 5 pops -> empty_o=1; 6th pop ignored.
//  4. Wrap: drive 40 advances with remote tracking -> ptr_gray sequence checked: Hamming distance 1
//     every step, 31 -> 0 included.
//  5. Random async remote: sweep each SYNC_STAGES value 2,3,4 -> remote_bin_o equals gray2bin of
//     the input delayed exactly SYNC_STAGES edges.
//  6. Mid-op reset: at ptr_bin=9, full=0, assert rst 1 cycle with inc_i=1 -> next edge all 0,
//     then resume counting from 0.

Source files
------------

// File: rtl/gray_ptr_sync_pkg.sv
// Shared pointer type and Gray-code helpers for the async-FIFO pointer logic.
// The helpers work on a wide zero-extended vector, so they are correct for any pointer width up to MAX_PW.
package gray_ptr_sync_pkg;

  localparam int MAX_PW = 32;

  typedef logic [MAX_PW-1:0] ptr_t;

  function automatic int pw_of(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[MAX_PW-1] = g[MAX_PW-1];
    for (int i = MAX_PW - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync_if.sv
// Bundle of pointer, flag and remote-pointer signals for one side of an async FIFO.
interface gray_ptr_sync_if
  import gray_ptr_sync_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
);
  localparam int PW = pw_of(ADDR_WIDTH);

  logic                  inc_i;
  logic [PW-1:0]         ptr_bin_o;
  logic [PW-1:0]         ptr_gray_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [PW-1:0]         remote_gray_i;
  logic [PW-1:0]         remote_bin_o;
  logic                  blocked_o;
  logic [PW-1:0]         level_o;

  modport master (
    input  inc_i, remote_gray_i,
    output ptr_bin_o, ptr_gray_o, addr_o, remote_bin_o, blocked_o, level_o
  );

  modport slave (
    output inc_i, remote_gray_i,
    input  ptr_bin_o, ptr_gray_o, addr_o, remote_bin_o, blocked_o, level_o
  );

endinterface

// File: rtl/gray_sync_chain.sv
// Multi-flop synchroniser for a Gray-coded pointer arriving from another clock domain.
module gray_sync_chain #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// One side of an async-FIFO pointer pair: local binary/Gray pointer, synchronised remote pointer,
// registered full/empty flag and occupancy level.
module gray_ptr_sync
  import gray_ptr_sync_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit IS_WRITE    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  gray_ptr_sync_if.master   bus
);

  localparam int PW = pw_of(ADDR_WIDTH);
  // Full means the pointers differ only in the two top Gray bits (one wrap apart).
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("gray_ptr_sync: SYNC_STAGES must be in 2..4");
  end

  logic [PW-1:0] ptr_bin;
  logic [PW-1:0] ptr_gray;
  logic [PW-1:0] bin_nxt;
  logic [PW-1:0] gray_nxt;
  logic [PW-1:0] sync_q;
  logic [PW-1:0] remote_bin;
  logic [PW-1:0] level;
  logic          blocked;
  logic          blocked_nxt;
  logic          adv;

  gray_sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.remote_gray_i),
    .q   (sync_q)
  );

  always_comb begin
    adv         = bus.inc_i & ~blocked;
    bin_nxt     = ptr_bin + PW'(adv);
    gray_nxt    = PW'(bin2gray(ptr_t'(bin_nxt)));
    remote_bin  = PW'(gray2bin(ptr_t'(sync_q)));
    blocked_nxt = 1'b0;
    level       = '0;
    // Flag is judged against the next pointer so it is valid alongside it.
    if (IS_WRITE) begin
      blocked_nxt = (gray_nxt == (sync_q ^ FULL_MASK));
      level       = ptr_bin - remote_bin;
    end else begin
      blocked_nxt = (gray_nxt == sync_q);
      level       = remote_bin - ptr_bin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_bin  <= '0;
      ptr_gray <= '0;
      blocked  <= (IS_WRITE == 1'b0);
    end else begin
      ptr_bin  <= bin_nxt;
      ptr_gray <= gray_nxt;
      blocked  <= blocked_nxt;
    end
  end

  assign bus.ptr_bin_o    = ptr_bin;
  assign bus.ptr_gray_o   = ptr_gray;
  assign bus.addr_o       = ptr_bin[ADDR_WIDTH-1:0];
  assign bus.remote_bin_o = remote_bin;
  assign bus.blocked_o    = blocked;
  assign bus.level_o      = level;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Scoreboard bench for gray_ptr_sync: write side, read side and read sides with 3 and 4 sync stages.
module tb_gray_ptr_sync;

  localparam int AW = 4;
  localparam int FLD_BIN = 0, FLD_GRAY = 1, FLD_BLK = 2, FLD_LVL = 3, FLD_RBIN = 4, FLD_ADDR = 5;
  localparam int I_WR = 0, I_RD = 1, I_RD3 = 2, I_RD4 = 3;
  localparam int TIMEOUT_NS = 100000;

  typedef struct {
    string       name;
    int          inst;
    int          field;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] mon_act;
  int n_compared;
  int n_mismatched;
  bit done;

  gray_ptr_sync_if #(.ADDR_WIDTH(AW)) wr_if ();
  gray_ptr_sync_if #(.ADDR_WIDTH(AW)) rd_if ();
  gray_ptr_sync_if #(.ADDR_WIDTH(AW)) rd3_if ();
  gray_ptr_sync_if #(.ADDR_WIDTH(AW)) rd4_if ();

  gray_ptr_sync #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .IS_WRITE(1'b1)) u_wr  (.clk(clk), .rst(rst), .bus(wr_if));
  gray_ptr_sync #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .IS_WRITE(1'b0)) u_rd  (.clk(clk), .rst(rst), .bus(rd_if));
  gray_ptr_sync #(.ADDR_WIDTH(AW), .SYNC_STAGES(3), .IS_WRITE(1'b0)) u_rd3 (.clk(clk), .rst(rst), .bus(rd3_if));
  gray_ptr_sync #(.ADDR_WIDTH(AW), .SYNC_STAGES(4), .IS_WRITE(1'b0)) u_rd4 (.clk(clk), .rst(rst), .bus(rd4_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: if the stimulus sequence never completes, the wait has expired and the run fails.
  initial begin
    #(TIMEOUT_NS);
    if (!done) begin
      $display("[TB] FAIL timeout: stimulus did not complete within %0d ns", TIMEOUT_NS);
      $finish;
    end
  end

  function automatic logic [4:0] g_of(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [4:0] b_of(input logic [4:0] g);
    logic [4:0] b;
    for (int i = 0; i < 5; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  function automatic logic [31:0] sample(input int inst, input int field);
    logic [4:0] bin, gray, lvl, rbin;
    logic [3:0] addr;
    logic       blk;
    case (inst)
      I_WR:    begin bin = wr_if.ptr_bin_o;  gray = wr_if.ptr_gray_o;  blk = wr_if.blocked_o;  lvl = wr_if.level_o;  rbin = wr_if.remote_bin_o;  addr = wr_if.addr_o;  end
      I_RD:    begin bin = rd_if.ptr_bin_o;  gray = rd_if.ptr_gray_o;  blk = rd_if.blocked_o;  lvl = rd_if.level_o;  rbin = rd_if.remote_bin_o;  addr = rd_if.addr_o;  end
      I_RD3:   begin bin = rd3_if.ptr_bin_o; gray = rd3_if.ptr_gray_o; blk = rd3_if.blocked_o; lvl = rd3_if.level_o; rbin = rd3_if.remote_bin_o; addr = rd3_if.addr_o; end
      default: begin bin = rd4_if.ptr_bin_o; gray = rd4_if.ptr_gray_o; blk = rd4_if.blocked_o; lvl = rd4_if.level_o; rbin = rd4_if.remote_bin_o; addr = rd4_if.addr_o; end
    endcase
    case (field)
      FLD_BIN:  return 32'(bin);
      FLD_GRAY: return 32'(gray);
      FLD_BLK:  return 32'(blk);
      FLD_LVL:  return 32'(lvl);
      FLD_RBIN: return 32'(rbin);
      default:  return 32'(addr);
    endcase
  endfunction

  // Monitor: drains expectations queued since the last active edge and compares them.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = sample(mon_e.inst, mon_e.field);
      n_compared++;
      if (mon_act !== mon_e.exp) begin
        n_mismatched++;
        $display("[TB] FAIL %s: got %0d, expected %0d", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic checkOutput(input string name, input int inst, input int field, input int exp);
    exp_t e;
    e.name  = name;
    e.inst  = inst;
    e.field = field;
    e.exp   = 32'(exp);
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic wr_inc, input logic rd_inc);
    wr_if.inc_i = wr_inc;
    rd_if.inc_i = rd_inc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int model;
    logic [4:0] v;
    logic [4:0] hist[$];
    done         = 1'b0;
    n_compared   = 0;
    n_mismatched = 0;
    rst = 1'b1;
    wr_if.remote_gray_i  = '0;
    rd_if.remote_gray_i  = '0;
    rd3_if.remote_gray_i = '0;
    rd4_if.remote_gray_i = '0;
    rd3_if.inc_i = 1'b0;
    rd4_if.inc_i = 1'b0;

    // Reset held with inc asserted
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("rst_wr_bin",  I_WR, FLD_BIN, 0);
    checkOutput("rst_wr_gray", I_WR, FLD_GRAY, 0);
    checkOutput("rst_wr_blk",  I_WR, FLD_BLK, 0);
    checkOutput("rst_wr_lvl",  I_WR, FLD_LVL, 0);
    checkOutput("rst_rd_blk",  I_RD, FLD_BLK, 1);
    checkOutput("rst_rd_bin",  I_RD, FLD_BIN, 0);
    checkOutput("rst_rd_rbin", I_RD, FLD_RBIN, 0);
    rst = 1'b0;

    // Write side fills to 16 with remote held at 0
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("fill_bin", I_WR, FLD_BIN, i);
      checkOutput("fill_blk", I_WR, FLD_BLK, (i == 16) ? 1 : 0);
    end
    checkOutput("full_gray", I_WR, FLD_GRAY, 24);
    checkOutput("full_lvl",  I_WR, FLD_LVL, 16);
    checkOutput("full_addr", I_WR, FLD_ADDR, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("full_ignored_bin", I_WR, FLD_BIN, 16);
    checkOutput("full_ignored_blk", I_WR, FLD_BLK, 1);

    // Read side sees remote write pointer 5 (Gray 7)
    rd_if.remote_gray_i = 5'd7;
    applyStimulus(1'b0, 1'b0);
    checkOutput("rd_sync1_rbin", I_RD, FLD_RBIN, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rd_sync2_rbin", I_RD, FLD_RBIN, 5);
    checkOutput("rd_sync2_lvl",  I_RD, FLD_LVL, 5);
    checkOutput("rd_sync2_blk",  I_RD, FLD_BLK, 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rd_empty_fall", I_RD, FLD_BLK, 0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("pop_bin", I_RD, FLD_BIN, i);
      checkOutput("pop_lvl", I_RD, FLD_LVL, 5 - i);
      checkOutput("pop_blk", I_RD, FLD_BLK, (i == 5) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("empty_ignored_bin", I_RD, FLD_BIN, 5);
    checkOutput("empty_ignored_blk", I_RD, FLD_BLK, 1);

    // Unblock the write side, then 40 advances across the wrap with the remote trailing
    wr_if.remote_gray_i = g_of(16);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("unblock_blk", I_WR, FLD_BLK, 0);
    checkOutput("unblock_lvl", I_WR, FLD_LVL, 0);
    model = 16;
    for (int i = 0; i < 40; i++) begin
      wr_if.remote_gray_i = g_of(model);
      applyStimulus(1'b1, 1'b0);
      model = (model + 1) % 32;
      checkOutput("wrap_bin",  I_WR, FLD_BIN, model);
      checkOutput("wrap_gray", I_WR, FLD_GRAY, int'(g_of(model)));
      checkOutput("wrap_blk",  I_WR, FLD_BLK, 0);
    end

    // Random remote pointer through 2, 3 and 4 stage synchronisers
    for (int n = 0; n < 20; n++) begin
      v = 5'($urandom_range(0, 31));
      hist.push_back(v);
      rd_if.remote_gray_i  = v;
      rd3_if.remote_gray_i = v;
      rd4_if.remote_gray_i = v;
      applyStimulus(1'b0, 1'b0);
      if (n + 1 >= 2) checkOutput("sync2_rbin", I_RD,  FLD_RBIN, int'(b_of(hist[n - 1])));
      if (n + 1 >= 3) checkOutput("sync3_rbin", I_RD3, FLD_RBIN, int'(b_of(hist[n - 2])));
      if (n + 1 >= 4) checkOutput("sync4_rbin", I_RD4, FLD_RBIN, int'(b_of(hist[n - 3])));
    end

    // Mid-operation reset at ptr_bin = 9
    wr_if.remote_gray_i = '0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("pre_rst_bin", I_WR, FLD_BIN, 9);
    checkOutput("pre_rst_blk", I_WR, FLD_BLK, 0);
    checkOutput("pre_rst_lvl", I_WR, FLD_LVL, 9);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("midrst_bin",  I_WR, FLD_BIN, 0);
    checkOutput("midrst_gray", I_WR, FLD_GRAY, 0);
    checkOutput("midrst_blk",  I_WR, FLD_BLK, 0);
    checkOutput("midrst_lvl",  I_WR, FLD_LVL, 0);
    checkOutput("midrst_rbin", I_WR, FLD_RBIN, 0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("resume_bin",  I_WR, FLD_BIN, i);
      checkOutput("resume_gray", I_WR, FLD_GRAY, int'(g_of(i)));
    end

    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    #1;
    done = 1'b1;
    if (n_mismatched != 0 || n_compared < 12 || exp_q.size() != 0) begin
      $display("[TB] FAIL end of run: %0d mismatched, %0d compared, %0d undrained",
               n_mismatched, n_compared, exp_q.size());
    end
    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
